// File: rtl/fp_mac_seq_if.sv
// Handshake bus of the sequential FP multiply-accumulate unit:
// neuron start/bias, operand stream and result stream.
interface fp_mac_seq_if #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] bias;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [W-1:0] x;
  logic [W-1:0] w;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         sat;
  logic         busy;

  modport master (
    output start, bias, in_valid, in_last, x, w, out_ready,
    input  in_ready, out_valid, out_data, sat, busy
  );

  modport slave (
    input  start, bias, in_valid, in_last, x, w, out_ready,
    output in_ready, out_valid, out_data, sat, busy
  );
endinterface

// File: rtl/fp_mac_seq.sv
// Sequential floating-point multiply-accumulate: acc = bias + sum(x*w), one pair
// per four clocks (WAIT/MUL/ADD/NORM), truncating, saturating, denormals flushed.
module fp_mac_seq #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mac_seq_if.slave  bus
);
  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 2;
  localparam int unsigned EW2  = EXP_W + 2;
  localparam int unsigned MW1  = MAN_W + 1;
  localparam int unsigned PW   = 2 * MW1;
  localparam int unsigned SW   = MAN_W + 2;
  localparam int unsigned LZ_W = $clog2(MAN_W + 2);

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp_t;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MUL, S_ADD, S_NORM, S_OUT} state_e;

  state_e state_q, state_d;

  fp_t              acc_q, xl_q, wl_q, prod_q, out_data_q;
  logic             last_q, sat_q, in_ready_q, out_valid_q, busy_q;
  logic             in_ready_d, out_valid_d, busy_d;
  logic             sum_s_q;
  logic [EXP_W-1:0] sum_e_q;
  logic [SW-1:0]    sum_m_q;

  // All-ones exponent has no Inf/NaN meaning: it reads as the largest finite value.
  function automatic fp_t decode(input fp_t v);
    fp_t r;
    r = v;
    if (&v.e) begin
      r.e = EXP_W'(EMAX);
      r.m = '1;
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start)     state_d = S_WAIT;
      S_WAIT:  if (bus.in_valid)  state_d = S_MUL;
      S_MUL:                      state_d = S_ADD;
      S_ADD:                      state_d = S_NORM;
      S_NORM:                     state_d = last_q ? S_OUT : S_WAIT;
      S_OUT:   if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the upcoming state
  always_comb begin
    in_ready_d  = (state_d == S_WAIT);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
  end

  // Multiply stage
  fp_t                   xa, wa, prod_d;
  logic [PW-1:0]         pm;
  logic signed [EW2-1:0] pe;
  logic [MAN_W-1:0]      pf;
  logic                  prod_ovf_c;

  always_comb begin
    xa         = decode(xl_q);
    wa         = decode(wl_q);
    pm         = PW'({1'b1, xa.m}) * PW'({1'b1, wa.m});
    pe         = $signed(EW2'(xa.e)) + $signed(EW2'(wa.e)) - $signed(EW2'(BIAS));
    pf         = pm[PW-3 -: MAN_W];
    prod_d     = '0;
    prod_ovf_c = 1'b0;
    if (pm[PW-1]) begin
      pf = pm[PW-2 -: MAN_W];
      pe = pe + $signed(EW2'(1));
    end
    if (xa.e == '0 || wa.e == '0) begin
      prod_d = '0;
    end else if (pe > $signed(EW2'(EMAX))) begin
      prod_d     = '{s: xa.s ^ wa.s, e: EXP_W'(EMAX), m: '1};
      prod_ovf_c = 1'b1;
    end else if (pe >= $signed(EW2'(1))) begin
      prod_d = '{s: xa.s ^ wa.s, e: pe[EXP_W-1:0], m: pf};
    end
  end

  // Align/add stage: larger exponent kept, smaller truncated by the difference
  fp_t              aa, ba;
  logic             big_s, sml_s, sum_s_d;
  logic [EXP_W-1:0] big_e, sml_e, diff;
  logic [MW1-1:0]   big_m, sml_m, sml_sh;
  logic [SW-1:0]    sum_m_d;

  always_comb begin
    aa = decode(acc_q);
    ba = decode(prod_q);
    if (ba.e > aa.e) begin
      big_s = ba.s; big_e = ba.e; big_m = {1'b1, ba.m};
      sml_s = aa.s; sml_e = aa.e; sml_m = (aa.e == '0) ? '0 : {1'b1, aa.m};
    end else begin
      big_s = aa.s; big_e = aa.e; big_m = (aa.e == '0) ? '0 : {1'b1, aa.m};
      sml_s = ba.s; sml_e = ba.e; sml_m = (ba.e == '0) ? '0 : {1'b1, ba.m};
    end
    diff   = big_e - sml_e;
    sml_sh = (32'(diff) > MAN_W + 1) ? '0 : (sml_m >> diff);
    if (big_s == sml_s) begin
      sum_m_d = SW'(big_m) + SW'(sml_sh);
      sum_s_d = big_s;
    end else if (big_m >= sml_sh) begin
      sum_m_d = SW'(big_m) - SW'(sml_sh);
      sum_s_d = big_s;
    end else begin
      sum_m_d = SW'(sml_sh) - SW'(big_m);
      sum_s_d = sml_s;
    end
    if (sum_m_d == '0) sum_s_d = 1'b0;
  end

  // Normalize stage
  fp_t                   norm_d;
  logic [LZ_W-1:0]       lzc;
  logic [SW-1:0]         nm;
  logic signed [EW2-1:0] ne;
  logic                  norm_ovf_c;

  always_comb begin
    lzc = '0;
    for (int i = 0; i <= int'(MAN_W); i++) begin
      if (sum_m_q[i]) lzc = LZ_W'(int'(MAN_W) - i);
    end
    ne         = $signed(EW2'(sum_e_q));
    nm         = sum_m_q << lzc;
    norm_d     = '0;
    norm_ovf_c = 1'b0;
    if (sum_m_q[SW-1]) begin
      nm = sum_m_q >> 1;
      ne = ne + $signed(EW2'(1));
    end else begin
      ne = ne - $signed(EW2'(lzc));
    end
    if (sum_m_q == '0) begin
      norm_d = '0;
    end else if (ne > $signed(EW2'(EMAX))) begin
      norm_d     = '{s: sum_s_q, e: EXP_W'(EMAX), m: '1};
      norm_ovf_c = 1'b1;
    end else if (ne >= $signed(EW2'(1))) begin
      norm_d = '{s: sum_s_q, e: ne[EXP_W-1:0], m: nm[MAN_W-1:0]};
    end
  end

  // Truncated product bits and the hidden/carry positions are deliberately dropped
  logic unused_bits_c;
  assign unused_bits_c = ^{pm[MAN_W-1:0], nm[SW-1:MAN_W]};

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      xl_q        <= '0;
      wl_q        <= '0;
      last_q      <= 1'b0;
      prod_q      <= '0;
      sum_s_q     <= 1'b0;
      sum_e_q     <= '0;
      sum_m_q     <= '0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      case (state_q)
        S_IDLE: if (bus.start) begin
          acc_q <= fp_t'(bus.bias);
          sat_q <= 1'b0;
        end
        S_WAIT: if (bus.in_valid) begin
          xl_q   <= fp_t'(bus.x);
          wl_q   <= fp_t'(bus.w);
          last_q <= bus.in_last;
        end
        S_MUL: begin
          prod_q <= prod_d;
          if (prod_ovf_c) sat_q <= 1'b1;
        end
        S_ADD: begin
          sum_s_q <= sum_s_d;
          sum_e_q <= big_e;
          sum_m_q <= sum_m_d;
        end
        S_NORM: begin
          acc_q <= norm_d;
          if (norm_ovf_c) sat_q <= 1'b1;
          if (last_q) out_data_q <= norm_d;
        end
        S_OUT: if (bus.out_ready) sat_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = W'(out_data_q);
  assign bus.sat       = sat_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fp_mac_seq.sv
// Directed bench for fp_mac_seq: table of neurons with hand-computed half-precision
// results, plus backpressure, ignored-start and mid-pipeline reset sequences.
module tb_fp_mac_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  fp_mac_seq_if bus ();

  fp_mac_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0]      bias;
    int               n;
    logic [2:0][15:0] xs;
    logic [2:0][15:0] ws;
    logic [15:0]      exp_data;
    logic             exp_sat;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [15:0] b, input int n,
                              input logic [15:0] x0, w0, x1, w1,
                              input logic [15:0] ed, input logic es);
    vec_t v;
    v.bias = b; v.n = n;
    v.xs = '0; v.ws = '0;
    v.xs[0] = x0; v.ws[0] = w0; v.xs[1] = x1; v.ws[1] = w1;
    v.exp_data = ed; v.exp_sat = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [15:0] b);
    bus.start = 1'b1; bus.bias = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] xv, input logic [15:0] wv, input logic lst);
    int t = 0;
    bus.x = xv; bus.w = wv; bus.in_last = lst; bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 50) begin tick(); t++; end
    if (t >= 50) chk("in_ready timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  // Called just after the last-pair accept edge; returns edges until out_valid.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin tick(); cyc++; end
  endtask

  task automatic take_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    do_start(v.bias);
    for (int p = 0; p < v.n; p++) send_pair(v.xs[p], v.ws[p], p == v.n - 1);
    wait_valid(lat);
    chk($sformatf("vec%0d latency", idx), lat, 3);
    chk($sformatf("vec%0d data", idx), bus.out_data, v.exp_data);
    chk($sformatf("vec%0d sat", idx), bus.sat, v.exp_sat);
    take_out();
    chk($sformatf("vec%0d valid_fall", idx), bus.out_valid, 1'b0);
    chk($sformatf("vec%0d busy_fall", idx), bus.busy, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " in_ready"}, bus.in_ready, 1'b0);
    chk({tag, " out_valid"}, bus.out_valid, 1'b0);
    chk({tag, " out_data"}, bus.out_data, 16'h0000);
    chk({tag, " sat"}, bus.sat, 1'b0);
    chk({tag, " busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, acc_n, cyc, last_cyc;

    vecs[0] = mk(16'h0000, 2, 16'h4000, 16'h3E00, 16'h3C00, 16'h3800, 16'h4300, 1'b0);
    vecs[1] = mk(16'h3C00, 1, 16'hBC00, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    vecs[2] = mk(16'h7BFF, 1, 16'h7BFF, 16'h4000, 16'h0000, 16'h0000, 16'h7BFF, 1'b1);
    vecs[3] = mk(16'h0000, 2, 16'h0400, 16'h0400, 16'h7C00, 16'h3C00, 16'h7BFF, 1'b0);
    vecs[4] = mk(16'h4000, 1, 16'hC200, 16'h3C00, 16'h0000, 16'h0000, 16'hBC00, 1'b0);
    vecs[5] = mk(16'h3C00, 1, 16'h1000, 16'h3C00, 16'h0000, 16'h0000, 16'h3C00, 1'b0);
    vecs[6] = mk(16'h3C00, 1, 16'h1400, 16'h3C00, 16'h0000, 16'h0000, 16'h3C01, 1'b0);

    rst_n = 1'b0;
    bus.start = 1'b0; bus.bias = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.x = '0; bus.w = '0; bus.out_ready = 1'b0;
    #12;
    chk_reset_outs("reset");
    @(negedge clk); rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Backpressure: in_valid held high, three 1.0*1.0 terms, stalled result
    do_start(16'h0000);
    bus.x = 16'h3C00; bus.w = 16'h3C00; bus.in_valid = 1'b1;
    acc_n = 0; cyc = 0; last_cyc = 0;
    while (acc_n < 3 && cyc < 100) begin
      if (bus.in_ready) begin
        if (acc_n > 0) chk($sformatf("bp interval%0d", acc_n), cyc - last_cyc, 4);
        last_cyc = cyc;
        bus.in_last = (acc_n == 2);
        acc_n++;
      end
      tick(); cyc++;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    if (acc_n < 3) chk("bp accept timeout", 32'd0, 32'd1);
    chk("bp in_ready drop", bus.in_ready, 1'b0);
    wait_valid(lat);
    chk("bp latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp stall%0d data", k), bus.out_data, 16'h4200);
      chk($sformatf("bp stall%0d valid", k), bus.out_valid, 1'b1);
      bus.start = (k == 2); bus.bias = 16'h5555;
      tick();
    end
    chk("bp sat", bus.sat, 1'b0);
    bus.start = 1'b1;
    take_out();
    bus.start = 1'b0;
    chk("bp valid_fall", bus.out_valid, 1'b0);
    chk("bp busy_fall", bus.busy, 1'b0);
    tick();
    chk("bp start ignored busy", bus.busy, 1'b0);
    chk("bp start ignored in_ready", bus.in_ready, 1'b0);

    // Reset asserted while the pipeline sits in ADD with sat already set
    do_start(16'h7BFF);
    send_pair(16'h7BFF, 16'h4000, 1'b1);
    tick();
    #2;
    chk("pre-reset sat", bus.sat, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midreset");
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("post-reset busy", bus.busy, 1'b0);
    run_vec(vecs[0], 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
